// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared wait-stated memory, with a watchdog that halts on a stalled memory.
module mc_ctrl_fsm #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEXEC = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Keep the counter at least one bit wide so a disabled watchdog still elaborates.
    localparam int CW        = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam int WD_LAST_I = (MEM_WAIT_MAX > 0) ? (MEM_WAIT_MAX - 1) : 0;
    localparam logic [CW-1:0] WD_LAST = WD_LAST_I[CW-1:0];
    localparam logic [CW-1:0] WD_SAT  = {CW{1'b1}};

    state_t        state_q, state_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          in_mem_state;
    logic          wd_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign in_mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign wd_hit       = (MEM_WAIT_MAX != 0) && (wd_cnt_q == WD_LAST) && !mem_ready;

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;

        case (state_q)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pc_en   = mem_ready;
                if (mem_ready)   state_d = DECODE;
                else if (wd_hit) state_d = HALT;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_RTYPE:      state_d = RTEXEC;
                    OP_LW, OP_SW:  state_d = MEMADR;
                    OP_BEQ:        state_d = BRANCH;
                    OP_ADDI:       state_d = ADDIEX;
                    OP_J:          state_d = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                if (mem_ready)   state_d = MEMWB;
                else if (wd_hit) state_d = HALT;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready;
                if (mem_ready)   state_d = FETCH;
                else if (wd_hit) state_d = HALT;
            end
            RTEXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                pcsrc      = 2'b01;
                pc_en      = zero;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pcsrc      = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            HALT: begin
                mem_err = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Wait counting restarts whenever the FSM moves, so each memory state gets its own budget.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_d != state_q)
            wd_cnt_d = '0;
        else if (in_mem_state && !mem_ready && (wd_cnt_q != WD_SAT))
            wd_cnt_d = wd_cnt_q + 1'b1;
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: each driven cycle queues its hand-derived
// expected output vector; a negedge monitor pops and compares.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       instr_done, illegal_op, mem_err;
    logic [3:0] dbg_state;

    mc_ctrl_fsm #(.MEM_WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .memread(memread), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
        .instr_done(instr_done), .illegal_op(illegal_op), .mem_err(mem_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // {pc_en,iord,memread,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
    //  alusrcb[2],aluop[2],pcsrc[2],instr_done,illegal_op,mem_err,state[4]}
    typedef logic [21:0] vec_t;
    typedef struct { vec_t v; string name; } exp_t;

    //                                 pc io mr mw ir rd mt rw sa  srcb   aluop  pcsrc  dn il er st
    localparam vec_t E_FETCH_R  = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0,4'd0};
    localparam vec_t E_FETCH_W  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0,4'd0};
    localparam vec_t E_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0,1'b0,4'd1};
    localparam vec_t E_DEC_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b1,1'b0,4'd1};
    localparam vec_t E_MEMADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0,4'd2};
    localparam vec_t E_MEMRD    = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,4'd3};
    localparam vec_t E_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,4'd4};
    localparam vec_t E_MEMWR_R  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,4'd5};
    localparam vec_t E_MEMWR_W  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,4'd5};
    localparam vec_t E_RTEXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0,4'd6};
    localparam vec_t E_ALUWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,4'd7};
    localparam vec_t E_BR_Z     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0,1'b0,4'd8};
    localparam vec_t E_BR_NZ    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0,1'b0,4'd8};
    localparam vec_t E_ADDIEX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0,4'd9};
    localparam vec_t E_ADDIWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,4'd10};
    localparam vec_t E_JUMP     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0,1'b0,4'd11};
    localparam vec_t E_HALT     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1,4'd15};

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_no = 0;

    wire vec_t act = {pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                      alusrcb, aluop, pcsrc, instr_done, illegal_op, mem_err, dbg_state};

    // Drives one cycle's inputs just after the clock edge and queues the expected outputs.
    task automatic step(input logic rn, input logic rdy, input logic z,
                        input logic [5:0] op, input vec_t e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n     = rn;
        mem_ready = rdy;
        zero      = z;
        opcode    = op;
        x.v       = e;
        x.name    = nm;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            step_no = step_no + 1;
            n_cmp = n_cmp + 1;
            if (act !== x.v) begin
                n_bad = n_bad + 1;
                $display("FAIL %s (step %0d): got %b state=%0d, required %b state=%0d",
                         x.name, step_no, act, act[3:0], x.v, x.v[3:0]);
            end else begin
                $display("ok   %s (step %0d): %b", x.name, step_no, act);
            end
        end
    end

    initial begin
        // reset held
        step(1'b0, 1'b1, 1'b0, OP_R, E_FETCH_R, "reset_fetch");
        step(1'b0, 1'b1, 1'b0, OP_R, E_FETCH_R, "reset_fetch2");
        // lw, no waits: 5 cycles
        step(1'b1, 1'b1, 1'b0, OP_LW, E_FETCH_R, "lw_fetch");
        step(1'b1, 1'b1, 1'b0, OP_LW, E_DECODE,  "lw_decode");
        step(1'b1, 1'b1, 1'b0, OP_LW, E_MEMADR,  "lw_memadr");
        step(1'b1, 1'b1, 1'b0, OP_LW, E_MEMRD,   "lw_memrd");
        step(1'b1, 1'b1, 1'b0, OP_LW, E_MEMWB,   "lw_memwb");
        // beq taken then not taken
        step(1'b1, 1'b1, 1'b1, OP_BEQ, E_FETCH_R, "beqt_fetch");
        step(1'b1, 1'b1, 1'b1, OP_BEQ, E_DECODE,  "beqt_decode");
        step(1'b1, 1'b1, 1'b1, OP_BEQ, E_BR_Z,    "beqt_branch");
        step(1'b1, 1'b1, 1'b0, OP_BEQ, E_FETCH_R, "beqn_fetch");
        step(1'b1, 1'b1, 1'b0, OP_BEQ, E_DECODE,  "beqn_decode");
        step(1'b1, 1'b1, 1'b0, OP_BEQ, E_BR_NZ,   "beqn_branch");
        // sw with 3 wait cycles in MEMWR
        step(1'b1, 1'b1, 1'b0, OP_SW, E_FETCH_R, "sw_fetch");
        step(1'b1, 1'b1, 1'b0, OP_SW, E_DECODE,  "sw_decode");
        step(1'b1, 1'b1, 1'b0, OP_SW, E_MEMADR,  "sw_memadr");
        step(1'b1, 1'b0, 1'b0, OP_SW, E_MEMWR_W, "sw_wait1");
        step(1'b1, 1'b0, 1'b0, OP_SW, E_MEMWR_W, "sw_wait2");
        step(1'b1, 1'b0, 1'b0, OP_SW, E_MEMWR_W, "sw_wait3");
        step(1'b1, 1'b1, 1'b0, OP_SW, E_MEMWR_R, "sw_done");
        // illegal opcode
        step(1'b1, 1'b1, 1'b0, OP_BAD, E_FETCH_R, "ill_fetch");
        step(1'b1, 1'b1, 1'b0, OP_BAD, E_DEC_ILL, "ill_decode");
        // addi aborted by reset in ADDIEX
        step(1'b1, 1'b1, 1'b0, OP_ADDI, E_FETCH_R, "addi_fetch");
        step(1'b1, 1'b1, 1'b0, OP_ADDI, E_DECODE,  "addi_decode");
        step(1'b0, 1'b1, 1'b0, OP_ADDI, E_FETCH_R, "addi_abort");
        // clean R-type
        step(1'b1, 1'b1, 1'b0, OP_R, E_FETCH_R, "r_fetch");
        step(1'b1, 1'b1, 1'b0, OP_R, E_DECODE,  "r_decode");
        step(1'b1, 1'b1, 1'b0, OP_R, E_RTEXEC,  "r_exec");
        step(1'b1, 1'b1, 1'b0, OP_R, E_ALUWB,   "r_aluwb");
        // full addi
        step(1'b1, 1'b1, 1'b0, OP_ADDI, E_FETCH_R, "addi2_fetch");
        step(1'b1, 1'b1, 1'b0, OP_ADDI, E_DECODE,  "addi2_decode");
        step(1'b1, 1'b1, 1'b0, OP_ADDI, E_ADDIEX,  "addi2_ex");
        step(1'b1, 1'b1, 1'b0, OP_ADDI, E_ADDIWB,  "addi2_wb");
        // jump
        step(1'b1, 1'b1, 1'b0, OP_J, E_FETCH_R, "j_fetch");
        step(1'b1, 1'b1, 1'b0, OP_J, E_DECODE,  "j_decode");
        step(1'b1, 1'b1, 1'b0, OP_J, E_JUMP,    "j_jump");
        // watchdog: 4 low FETCH cycles then HALT, held until reset
        step(1'b1, 1'b0, 1'b0, OP_R, E_FETCH_W, "wd_fetch1");
        step(1'b1, 1'b0, 1'b0, OP_R, E_FETCH_W, "wd_fetch2");
        step(1'b1, 1'b0, 1'b0, OP_R, E_FETCH_W, "wd_fetch3");
        step(1'b1, 1'b0, 1'b0, OP_R, E_FETCH_W, "wd_fetch4");
        step(1'b1, 1'b0, 1'b0, OP_R, E_HALT,    "wd_halt1");
        step(1'b1, 1'b1, 1'b0, OP_R, E_HALT,    "wd_halt2");
        step(1'b0, 1'b0, 1'b0, OP_R, E_FETCH_W, "wd_reset");
        step(1'b1, 1'b1, 1'b0, OP_R, E_FETCH_R, "wd_recover");
        step(1'b1, 1'b1, 1'b0, OP_R, E_DECODE,  "wd_recover_dec");

        // bounded drain of the scoreboard
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control FSM for the MIPS core; replaces single-cycle main decoding on the shared-memory datapath.
- Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq, addi and j.
- Drives datapath mux selects and enables, and handshakes with a single shared instruction/data memory that can insert wait states.
- A watchdog halts the core when memory stops responding.

Parameters:
MEM_WAIT_MAX, 15, max consecutive cycles mem_ready may stay low in one memory state before HALT; 0 disables the watchdog.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
pc_en  out  1  PC register load enable
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memread  out  1  memory read request
memwrite  out  1  memory write request
irwrite  out  1  instruction register load
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = MDR, 0 = ALUOut
regwrite  out  1  register file write
alusrca  out  1  0 = PC, 1 = reg A
alusrcb  out  2  00 = reg B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
aluop  out  2  00 = add, 01 = sub, 10 = funct-decoded
pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
mem_err  out  1  high while in HALT
dbg_state  out  4  current state code

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- State register only; all outputs are combinational from state. Exceptions: FETCH/MEMRD/MEMWR qualify by mem_ready, and BRANCH qualifies by zero.
- Any output not listed for a state is 0.
- State codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, ALUWB=7
  - BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=15
  - Codes 12-14 are unused and go to FETCH on the next clock.
- Reset: state=FETCH and the watchdog counter clears, asynchronously. Outputs then follow FETCH: memread=1, alusrcb=01, and irwrite=pc_en=mem_ready. Everything else is 0.
- Reset mid-instruction aborts the instruction with no further enables.
- FETCH:
  - Outputs: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=pc_en=mem_ready.
  - Moves to DECODE when mem_ready=1; otherwise stays.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by opcode:
  - 000000 -> RTEXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - other -> FETCH with illegal_op=1 (no state change, no writes)
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD if opcode=100011, else MEMWR.
- MEMRD: iord=1, memread=1. Waits for mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1. Then FETCH.
- MEMWR: iord=1, memwrite=1, instr_done=mem_ready. Waits for mem_ready, then FETCH.
- RTEXEC: alusrca=1, alusrcb=00, aluop=10. Then ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1. Then FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pc_en=zero, instr_done=1. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1. Then FETCH.
- JUMP: pcsrc=10, pc_en=1, instr_done=1. Then FETCH.
- Cycle counts with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
- Watchdog:
  - Counter width $clog2(MEM_WAIT_MAX+1).
  - Cleared on every state transition.
  - Increments each cycle in FETCH/MEMRD/MEMWR with mem_ready=0; saturates.
  - If counter==MEM_WAIT_MAX-1 and mem_ready=0, next state is HALT. The fault cycle is the MEM_WAIT_MAX-th consecutive low cycle.
  - mem_ready=1 on that same cycle wins: normal transition.
- HALT: mem_err=1 and all enables/requests are 0. Exits only on reset.
- opcode is sampled only in DECODE and MEMADR; the IR is stable there by construction.

Test Plan:
- Reset released, mem_ready=1, lw (opcode 100011) -> dbg_state 0,1,2,3,4,0. irwrite=pc_en=1 in cycle 1, iord=1 and memread=1 in state 3, regwrite=memtoreg=1 and instr_done=1 in state 4.
- beq with zero=1, then zero=0 -> state 8 both times, pcsrc=01 and aluop=01. pc_en=1 the first time, 0 the second. instr_done=1 both times. 3 cycles each.
- sw with mem_ready held low 3 cycles in MEMWR -> memwrite=1 and iord=1 for 4 cycles. instr_done only on the 4th (mem_ready=1). Then FETCH, mem_err=0.
- MEM_WAIT_MAX=4, mem_ready=0 in FETCH -> 4 FETCH cycles, then dbg_state=15 and mem_err=1, all enables 0. rst_n low clears to FETCH and mem_err=0.
- Opcode 111111 -> DECODE shows illegal_op=1 for one cycle, then FETCH. regwrite, memwrite and pc_en are never asserted.
- rst_n pulsed low during ADDIEX -> immediate FETCH outputs with no regwrite. Then a clean R-type runs 0,1,6,7,0 with regdst=1, regwrite=1 in state 7, aluop=10 in state 6.
